// File: rtl/md_demux_arb.sv
// Mobile-device / base-station demux: handover FSM with hysteresis, response
// arbitration (committed BS first, then round-robin) and an MD-side data FIFO.
module md_demux_arb #(
    parameter int NUM_BS     = 3,
    parameter int DATA_W     = 4,
    parameter int SQ_W       = 2,
    parameter int HOLD_CYC   = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int TGT_W     = $clog2(NUM_BS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_BS-1:0]        bs_request,
    input  logic [NUM_BS-1:0]        bs_respond,
    input  logic [NUM_BS*DATA_W-1:0] bs_data,
    input  logic [TGT_W-1:0]         md_target,
    input  logic [NUM_BS*SQ_W-1:0]   md_sq,
    input  logic                     md_ready,
    output logic                     compare_enable,
    output logic [TGT_W-1:0]         bs_target,
    output logic                     bs_target_valid,
    output logic [NUM_BS*SQ_W-1:0]   bs_sq,
    output logic [NUM_BS-1:0]        bs_sq_valid,
    output logic [DATA_W-1:0]        md_data,
    output logic                     md_data_valid,
    output logic                     handover,
    output logic                     overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TGT_W-1:0] NO_TGT   = TGT_W'(NUM_BS);
    localparam logic [TGT_W-1:0] RR_INIT  = TGT_W'(NUM_BS - 1);
    localparam logic [7:0]       HOLD     = 8'(HOLD_CYC);
    localparam logic             HOLD_ONE = (HOLD_CYC == 1);
    localparam logic [AW:0]      FULL_CNT = FIFO_DEPTH[AW:0];

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LINKED  = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [TGT_W-1:0]  tgt_reg, tgt_next;
    logic [TGT_W-1:0]  pend_reg, pend_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic              handover_reg, handover_next;
    logic              commit;
    logic [TGT_W-1:0]  tgt_norm;

    logic              ce_reg;
    logic [TGT_W-1:0]  rr_reg;
    logic [NUM_BS*SQ_W-1:0] sq_reg;
    logic [NUM_BS-1:0] sqv_reg;
    logic              grant_any;
    logic [TGT_W-1:0]  grant_idx;
    logic [NUM_BS-1:0] grant_oh;
    logic [NUM_BS*SQ_W-1:0] sq_grant;
    logic [DATA_W-1:0] data_terms [NUM_BS];
    logic [DATA_W-1:0] push_data;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_next;
    logic [AW:0]       count_reg, count_next;
    logic [DATA_W-1:0] data_reg;
    logic              ovf_reg;
    logic              push, pop, full;

    // All "no target" codes collapse to NUM_BS so they compare equal to each other.
    assign tgt_norm = (md_target >= NO_TGT) ? NO_TGT : md_target;

    always_comb begin
        state_next    = state_reg;
        tgt_next      = tgt_reg;
        pend_next     = pend_reg;
        cnt_next      = cnt_reg;
        handover_next = 1'b0;
        commit        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (tgt_norm != NO_TGT) begin
                    state_next    = ST_LINKED;
                    tgt_next      = tgt_norm;
                    handover_next = 1'b1;
                end
            end
            ST_LINKED: begin
                if (tgt_norm != tgt_reg) begin
                    state_next = ST_PENDING;
                    pend_next  = tgt_norm;
                    cnt_next   = 8'd1;
                    commit     = HOLD_ONE;
                end
            end
            ST_PENDING: begin
                if (tgt_norm == tgt_reg) begin
                    state_next = ST_LINKED;
                    cnt_next   = 8'd0;
                end else if (tgt_norm != pend_reg) begin
                    pend_next = tgt_norm;
                    cnt_next  = 8'd1;
                    commit    = HOLD_ONE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                    commit   = ((cnt_reg + 8'd1) >= HOLD);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (commit) begin
            handover_next = 1'b1;
            cnt_next      = 8'd0;
            if (tgt_norm == NO_TGT) begin
                state_next = ST_IDLE;
                tgt_next   = NO_TGT;
            end else begin
                state_next = ST_LINKED;
                tgt_next   = tgt_norm;
            end
        end
    end

    // Committed BS has priority; otherwise search above the pointer, then wrap.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (state_reg != ST_IDLE) begin
            for (int i = 0; i < NUM_BS; i++) begin
                if (bs_respond[i] && (tgt_reg == TGT_W'(i))) begin
                    grant_any = 1'b1;
                    grant_idx = TGT_W'(i);
                end
            end
        end
        for (int i = 0; i < NUM_BS; i++) begin
            if (!grant_any && bs_respond[i] && (TGT_W'(i) > rr_reg)) begin
                grant_any = 1'b1;
                grant_idx = TGT_W'(i);
            end
        end
        for (int i = 0; i < NUM_BS; i++) begin
            if (!grant_any && bs_respond[i] && (TGT_W'(i) <= rr_reg)) begin
                grant_any = 1'b1;
                grant_idx = TGT_W'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BS; gi++) begin : g_bs
            assign grant_oh[gi] = grant_any && (grant_idx == TGT_W'(gi));
            assign sq_grant[gi*SQ_W +: SQ_W] = grant_oh[gi] ? md_sq[gi*SQ_W +: SQ_W] : '0;
            assign data_terms[gi] = grant_oh[gi] ? bs_data[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        push_data = '0;
        for (int i = 0; i < NUM_BS; i++) begin
            push_data = push_data | data_terms[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            tgt_reg      <= NO_TGT;
            pend_reg     <= NO_TGT;
            cnt_reg      <= 8'd0;
            handover_reg <= 1'b0;
            ce_reg       <= 1'b0;
            rr_reg       <= RR_INIT;
            sq_reg       <= '0;
            sqv_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            tgt_reg      <= tgt_next;
            pend_reg     <= pend_next;
            cnt_reg      <= cnt_next;
            handover_reg <= handover_next;
            ce_reg       <= |bs_request;
            sqv_reg      <= grant_oh;
            if (grant_any) begin
                rr_reg <= grant_idx;
                sq_reg <= sq_grant;
            end
        end
    end

    assign pop        = (count_reg != '0) && md_ready;
    assign full       = (count_reg == FULL_CNT);
    assign push       = grant_any && (!full || pop);
    assign rd_next    = rd_ptr_reg + AW'(pop);
    assign count_next = count_reg + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Head register: holds its value once the FIFO drains; bypasses the
    // incoming word when it becomes the only entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            data_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_next;
            count_reg  <= count_next;
            if (grant_any && full && !pop) begin
                ovf_reg <= 1'b1;
            end
            if (count_next != '0) begin
                if ((count_reg == '0) || (pop && (count_reg == (AW+1)'(1)))) begin
                    data_reg <= push_data;
                end else begin
                    data_reg <= mem[rd_next];
                end
            end
        end
    end

    assign compare_enable  = ce_reg;
    assign bs_target       = tgt_reg;
    assign bs_target_valid = (state_reg != ST_IDLE);
    assign bs_sq           = sq_reg;
    assign bs_sq_valid     = sqv_reg;
    assign md_data         = data_reg;
    assign md_data_valid   = (count_reg != '0);
    assign handover        = handover_reg;
    assign overflow        = ovf_reg;

endmodule

// File: doc/md_demux_arb.md
MD_DEMUX_ARB -- requirements
Module: md_demux_arb

Interface
REQ-001 SHALL have parameter NUM_BS, default 3, number of base-station channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 4, data width per channel.
REQ-003 SHALL have parameter SQ_W, default 2, signal-quality width per channel.
REQ-004 SHALL have parameter HOLD_CYC, default 4, handover hysteresis in cycles (1..255).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, MD-side data buffer entries (power of 2, >=2).
REQ-006 SHALL derive TGT_W = clog2(NUM_BS+1); target code NUM_BS or above means "no target".
REQ-007 Ports SHALL be:
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-low.
  bs_request  in  NUM_BS  per-BS request.
  bs_respond  in  NUM_BS  per-BS response strobe.
  bs_data  in  NUM_BS*DATA_W  per-BS data; slice i belongs to BS i.
  md_target  in  TGT_W  requested target BS from MD.
  md_sq  in  NUM_BS*SQ_W  per-BS signal quality from MD.
  md_ready  in  1  MD accepts data.
  compare_enable  out  1  any-request indication.
  bs_target  out  TGT_W  committed target, broadcast to all BS.
  bs_target_valid  out  1  bs_target is a real BS.
  bs_sq  out  NUM_BS*SQ_W  quality forwarded to granted BS.
  bs_sq_valid  out  NUM_BS  one-hot grant of the current cycle's sq.
  md_data  out  DATA_W  FIFO head.
  md_data_valid  out  1  FIFO not empty.
  handover  out  1  one-cycle pulse on target commit change.
  overflow  out  1  sticky, response dropped.

Function
REQ-008 compare_enable SHALL equal the OR of bs_request, registered (1-cycle latency).
REQ-009 Target FSM SHALL have states IDLE, LINKED, PENDING; reset state IDLE.
REQ-010 IDLE: valid md_target -> commit immediately, LINKED, bs_target_valid=1 next cycle, handover=1; no target -> stay IDLE.
REQ-011 LINKED: md_target != bs_target -> PENDING, hold counter=1; otherwise stay.
REQ-012 PENDING: md_target equal to bs_target -> LINKED, counter cleared; md_target differs from the value that entered PENDING -> restart counter at 1 with the new value.
REQ-013 PENDING: counter reaching HOLD_CYC with stable md_target -> commit; valid value -> LINKED, handover=1; no-target value -> IDLE, bs_target=NUM_BS, bs_target_valid=0, handover=1.
REQ-014 With HOLD_CYC=1, a change SHALL commit on the first cycle it is seen.
REQ-015 Response arbitration each cycle: committed BS wins if responding; otherwise round-robin among responders starting after last granted index, wrapping at NUM_BS-1 to 0.
REQ-016 Granted BS i: bs_sq slice i <= md_sq slice i, bs_sq_valid <= one-hot i, bs_data slice i pushed into FIFO, all registered.
REQ-017 No responder: bs_sq_valid <= 0, bs_sq holds, no push, round-robin pointer unchanged.
REQ-018 bs_sq slices of non-granted BS SHALL be 0; undriven/X values SHALL never appear.
REQ-019 FIFO: push visible on md_data one cycle after respond; pop when md_data_valid && md_ready.
REQ-020 Full with no pop: push dropped, overflow set until reset; full with pop: push and pop both occur.
REQ-021 Empty with md_ready=1: no pop, md_data holds last value.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; count tracks 0..FIFO_DEPTH exactly.

Reset
REQ-023 reset low SHALL immediately clear: compare_enable=0, bs_target=NUM_BS, bs_target_valid=0, bs_sq=0, bs_sq_valid=0, md_data=0, md_data_valid=0, handover=0, overflow=0, FIFO empty, round-robin pointer=NUM_BS-1, FSM IDLE.
REQ-024 Reset asserted mid-PENDING or with FIFO non-empty SHALL discard all state; first post-reset edge behaves as from IDLE.

Verification
REQ-025 NUM_BS=3: md_target=1 from reset -> next cycle bs_target=1, valid=1, handover pulse 1 cycle.
REQ-026 LINKED on 1, HOLD_CYC=4: md_target=2 for 3 cycles then 1 -> no commit, no handover; md_target=2 for 4 cycles -> bs_target=2, handover once.
REQ-027 bs_respond=3'b111, committed=2 -> grant 2; committed none, three cycles all responding -> grants 0,1,2 in order, bs_sq_valid one-hot each.
REQ-028 FIFO_DEPTH=4, md_ready=0, 5 responses data 1..5 -> valid, head=1, overflow=1; then md_ready=1 -> reads 1,2,3,4, then md_data_valid=0.
REQ-029 md_target=3 (none) for HOLD_CYC cycles while LINKED -> bs_target_valid=0, state IDLE, handover pulse.
REQ-030 reset low during PENDING with 2 FIFO entries -> all outputs at REQ-023 values asynchronously, no clock edge needed.
